// File: rtl/cnt_down_m.sv
// cnt_down_m: loadable modulo-MODEL down-counter / interval timer.
// Counts from a programmed reload value down to 0 and emits a one-cycle
// terminal-count pulse. Control is an IDLE/RUN/DONE state machine.
//
// Optional feature macro: CNT_DOWN_AUTORELOAD_EN
//   defined   : on reaching 0 the count reloads from rld and keeps running
//               (DONE is never entered)
//   undefined : one-shot; on reaching 0 the counter parks in DONE at 0
//
// Parameters:
//   WIDTH     counter width in bits
//   MODEL     modulus, legal counts 0..MODEL-1 (1 <= MODEL <= 2**WIDTH)
// Ports:
//   sys_clk   clock, rising edge
//   sys_rst_n asynchronous active-low reset
//   clr       synchronous clear to IDLE, cnt reloaded from rld
//   load_en   load clamped load_val into rld and cnt
//   load_val  reload value, clamped to MODEL-1
//   start     begin counting (IDLE) or restart from rld (DONE)
//   pause     hold cnt while in RUN
//   cnt       current count
//   tc        terminal-count pulse
//   busy      high while in RUN
//   done      high while in DONE
module cnt_down_m #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MODEL = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clr,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODEL - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] rld;
  logic [WIDTH-1:0] rld_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             tc_nxt;
  logic [WIDTH-1:0] load_v;

  // Clamp the requested reload value into the legal count range.
  assign load_v = (load_val > CNT_MAX) ? CNT_MAX : load_val;

  // State and datapath registers; busy/done are flopped decodes of the next state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
      cnt   <= CNT_MAX;
      rld   <= CNT_MAX;
      tc    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rld   <= rld_nxt;
      tc    <= tc_nxt;
      busy  <= (state_nxt == ST_RUN);
      done  <= (state_nxt == ST_DONE);
    end
  end

  // Next-state and datapath logic; priority clr > load_en > start > pause.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rld_nxt   = rld;
    tc_nxt    = 1'b0;

    if (clr) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = rld;
    end else if (load_en) begin
      // A load on the terminal cycle wins: no tc, RUN keeps running.
      rld_nxt = load_v;
      cnt_nxt = load_v;
      if (state == ST_DONE) begin
        state_nxt = ST_IDLE;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          // start is ignored while running.
          if (!pause) begin
            if (cnt != '0) begin
              cnt_nxt = cnt - WIDTH'(1);
            end else begin
              tc_nxt = 1'b1;
`ifdef CNT_DOWN_AUTORELOAD_EN
              cnt_nxt = rld;
`else
              state_nxt = ST_DONE;
`endif
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            state_nxt = ST_RUN;
            cnt_nxt   = rld;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_down_m.sv
// Testbench for cnt_down_m: directed vector table, hand-written corner
// sequences and randomized stimulus against a behavioural model.
// Two instances: default (WIDTH=4, MODEL=16) and WIDTH=5, MODEL=16 for clamping.
module tb_cnt_down_m;

  localparam int MOD = 16;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       clr       = 1'b0;
  logic       load_en   = 1'b0;
  logic       start     = 1'b0;
  logic       pause     = 1'b0;
  logic [3:0] load_val4 = '0;
  logic [4:0] load_val5 = '0;

  logic [3:0] cnt4;
  logic       tc4, busy4, done4;
  logic [4:0] cnt5;
  logic       tc5, busy5, done5;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state per instance: count, reload, running, finished, tc.
  int m_cnt [2];
  int m_rld [2];
  bit m_run [2];
  bit m_fin [2];
  bit m_tc  [2];

  typedef struct {
    logic       c;
    logic       le;
    logic [3:0] lv;
    logic       st;
    logic       ps;
    int         e_cnt;
    logic       e_tc;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tbl [12];

  cnt_down_m u_dut4 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (clr),
    .load_en   (load_en),
    .load_val  (load_val4),
    .start     (start),
    .pause     (pause),
    .cnt       (cnt4),
    .tc        (tc4),
    .busy      (busy4),
    .done      (done4)
  );

  cnt_down_m #(.WIDTH(5), .MODEL(16)) u_dut5 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (clr),
    .load_en   (load_en),
    .load_val  (load_val5),
    .start     (start),
    .pause     (pause),
    .cnt       (cnt5),
    .tc        (tc5),
    .busy      (busy5),
    .done      (done5)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = MOD - 1;
      m_rld[k] = MOD - 1;
      m_run[k] = 1'b0;
      m_fin[k] = 1'b0;
      m_tc[k]  = 1'b0;
    end
  endfunction

  // One clock edge of the specified behaviour, written in terms of flags.
  function automatic void model_step(input int k, input bit c, input bit le,
                                     input int lv, input bit st, input bit ps);
    int v;
    v = (lv > MOD - 1) ? MOD - 1 : lv;
    m_tc[k] = 1'b0;
    if (c) begin
      m_run[k] = 1'b0;
      m_fin[k] = 1'b0;
      m_cnt[k] = m_rld[k];
    end else if (le) begin
      m_rld[k] = v;
      m_cnt[k] = v;
      m_fin[k] = 1'b0;
    end else if (m_fin[k]) begin
      if (st) begin
        m_fin[k] = 1'b0;
        m_run[k] = 1'b1;
        m_cnt[k] = m_rld[k];
      end
    end else if (!m_run[k]) begin
      if (st) m_run[k] = 1'b1;
    end else if (!ps) begin
      if (m_cnt[k] > 0) begin
        m_cnt[k] = m_cnt[k] - 1;
      end else begin
        m_tc[k] = 1'b1;
`ifdef CNT_DOWN_AUTORELOAD_EN
        m_cnt[k] = m_rld[k];
`else
        m_run[k] = 1'b0;
        m_fin[k] = 1'b1;
`endif
      end
    end
  endfunction

  task automatic cmp_model();
    chk("mdl_cnt4",  int'(cnt4),  m_cnt[0]);
    chk("mdl_tc4",   int'(tc4),   int'(m_tc[0]));
    chk("mdl_busy4", int'(busy4), int'(m_run[0]));
    chk("mdl_done4", int'(done4), int'(m_fin[0]));
    chk("mdl_cnt5",  int'(cnt5),  m_cnt[1]);
    chk("mdl_tc5",   int'(tc5),   int'(m_tc[1]));
    chk("mdl_busy5", int'(busy5), int'(m_run[1]));
    chk("mdl_done5", int'(done5), int'(m_fin[1]));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare.
  task automatic apply(input logic c, input logic le, input logic [3:0] lv4,
                       input logic [4:0] lv5, input logic st, input logic ps);
    clr       = c;
    load_en   = le;
    load_val4 = lv4;
    load_val5 = lv5;
    start     = st;
    pause     = ps;
    @(posedge sys_clk);
    model_step(0, c, le, int'(lv4), st, ps);
    model_step(1, c, le, int'(lv5), st, ps);
    #1;
    cmp_model();
  endtask

  task automatic exp4(input string nm, input int e_cnt, input int e_tc,
                      input int e_busy, input int e_done);
    chk({nm, "_cnt"},  int'(cnt4),  e_cnt);
    chk({nm, "_tc"},   int'(tc4),   e_tc);
    chk({nm, "_busy"}, int'(busy4), e_busy);
    chk({nm, "_done"}, int'(done4), e_done);
  endtask

  task automatic step(input string nm, input logic c, input logic le,
                      input logic [3:0] lv4, input logic [4:0] lv5,
                      input logic st, input logic ps, input int e_cnt,
                      input int e_tc, input int e_busy, input int e_done);
    apply(c, le, lv4, lv5, st, ps);
    exp4(nm, e_cnt, e_tc, e_busy, e_done);
  endtask

  initial begin
    // Vector table: reset-idle hold, load 5, start, count down to terminal.
    tbl[0]  = '{c:0, le:0, lv:4'd0, st:0, ps:0, e_cnt:15, e_tc:0, e_busy:0, e_done:0};
    tbl[1]  = '{c:0, le:1, lv:4'd5, st:0, ps:0, e_cnt:5,  e_tc:0, e_busy:0, e_done:0};
    tbl[2]  = '{c:0, le:0, lv:4'd0, st:1, ps:0, e_cnt:5,  e_tc:0, e_busy:1, e_done:0};
    tbl[3]  = '{c:0, le:0, lv:4'd0, st:0, ps:0, e_cnt:4,  e_tc:0, e_busy:1, e_done:0};
    tbl[4]  = '{c:0, le:0, lv:4'd0, st:0, ps:0, e_cnt:3,  e_tc:0, e_busy:1, e_done:0};
    tbl[5]  = '{c:0, le:0, lv:4'd0, st:0, ps:0, e_cnt:2,  e_tc:0, e_busy:1, e_done:0};
    tbl[6]  = '{c:0, le:0, lv:4'd0, st:0, ps:0, e_cnt:1,  e_tc:0, e_busy:1, e_done:0};
    tbl[7]  = '{c:0, le:0, lv:4'd0, st:0, ps:0, e_cnt:0,  e_tc:0, e_busy:1, e_done:0};
`ifdef CNT_DOWN_AUTORELOAD_EN
    tbl[8]  = '{c:0, le:0, lv:4'd0, st:0, ps:0, e_cnt:5,  e_tc:1, e_busy:1, e_done:0};
    tbl[9]  = '{c:0, le:0, lv:4'd0, st:0, ps:0, e_cnt:4,  e_tc:0, e_busy:1, e_done:0};
    tbl[10] = '{c:0, le:0, lv:4'd0, st:1, ps:0, e_cnt:3,  e_tc:0, e_busy:1, e_done:0};
    tbl[11] = '{c:0, le:0, lv:4'd0, st:0, ps:0, e_cnt:2,  e_tc:0, e_busy:1, e_done:0};
`else
    tbl[8]  = '{c:0, le:0, lv:4'd0, st:0, ps:0, e_cnt:0,  e_tc:1, e_busy:0, e_done:1};
    tbl[9]  = '{c:0, le:0, lv:4'd0, st:0, ps:0, e_cnt:0,  e_tc:0, e_busy:0, e_done:1};
    tbl[10] = '{c:0, le:0, lv:4'd0, st:1, ps:0, e_cnt:5,  e_tc:0, e_busy:1, e_done:0};
    tbl[11] = '{c:0, le:0, lv:4'd0, st:0, ps:0, e_cnt:4,  e_tc:0, e_busy:1, e_done:0};
`endif

    // Reset state.
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    exp4("rst", 15, 0, 0, 0);
    chk("rst_cnt5", int'(cnt5), 15);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].c, tbl[i].le, tbl[i].lv, {1'b0, tbl[i].lv}, tbl[i].st, tbl[i].ps);
      exp4($sformatf("tbl%0d", i), tbl[i].e_cnt, int'(tbl[i].e_tc),
           int'(tbl[i].e_busy), int'(tbl[i].e_done));
    end

    // Clear back to IDLE, then clamp: 20 on a 5-bit MODEL=16 counter gives 15.
    step("clr",   1, 0, 4'd0,  5'd0,  0, 0, 5,  0, 0, 0);
    step("ld12",  0, 1, 4'd12, 5'd20, 0, 0, 12, 0, 0, 0);
    chk("clamp_cnt5", int'(cnt5), 15);
    step("go12",  0, 0, 4'd0,  5'd0,  1, 0, 12, 0, 1, 0);
    step("d11",   0, 0, 4'd0,  5'd0,  0, 0, 11, 0, 1, 0);
    step("d10",   0, 0, 4'd0,  5'd0,  0, 0, 10, 0, 1, 0);
    step("d9",    0, 0, 4'd0,  5'd0,  0, 0, 9,  0, 1, 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("pause%0d", i), 0, 0, 4'd0, 5'd0, 0, 1, 9, 0, 1, 0);
    step("resume", 0, 0, 4'd0, 5'd0, 0, 0, 8, 0, 1, 0);

    // Load at cnt==0 in RUN beats the terminal count; clr beats start.
    step("ld2",   0, 1, 4'd2,  5'd2,  0, 0, 2, 0, 1, 0);
    step("d1",    0, 0, 4'd0,  5'd0,  0, 0, 1, 0, 1, 0);
    step("d0",    0, 0, 4'd0,  5'd0,  0, 0, 0, 0, 1, 0);
    step("ldtc",  0, 1, 4'd7,  5'd7,  0, 0, 7, 0, 1, 0);
    step("clrst", 1, 0, 4'd0,  5'd0,  1, 0, 7, 0, 0, 0);

    // Asynchronous reset between edges while running at cnt==4.
    step("go7",   0, 0, 4'd0,  5'd0,  1, 0, 7, 0, 1, 0);
    step("r6",    0, 0, 4'd0,  5'd0,  0, 0, 6, 0, 1, 0);
    step("r5",    0, 0, 4'd0,  5'd0,  0, 0, 5, 0, 1, 0);
    step("r4",    0, 0, 4'd0,  5'd0,  0, 0, 4, 0, 1, 0);
    #3 sys_rst_n = 1'b0;
    #1;
    exp4("arst", 15, 0, 0, 0);
    chk("arst_cnt5", int'(cnt5), 15);
    model_reset();
    #1 sys_rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      apply(logic'($urandom_range(0, 99) < 3),
            logic'($urandom_range(0, 99) < 8),
            4'($urandom_range(0, 15)),
            5'($urandom_range(0, 31)),
            logic'($urandom_range(0, 99) < 25),
            logic'($urandom_range(0, 99) < 25));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
